// File: rtl/rv_pkg.sv
// RV32I decode constants plus the ALU operation and result-select encodings
// shared by the ID stage and its operand mux.
package rv_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_NOP  = 8'd0,
        ALU_ADD  = 8'd1,
        ALU_SUB  = 8'd2,
        ALU_SLL  = 8'd3,
        ALU_SLT  = 8'd4,
        ALU_SLTU = 8'd5,
        ALU_XOR  = 8'd6,
        ALU_SRL  = 8'd7,
        ALU_SRA  = 8'd8,
        ALU_OR   = 8'd9,
        ALU_AND  = 8'd10
    } aluop_e;

    typedef enum logic [ALUSEL_W-1:0] {
        SEL_NONE  = 3'd0,
        SEL_ARITH = 3'd1,
        SEL_CMP   = 3'd2,
        SEL_LOGIC = 3'd3,
        SEL_SHIFT = 3'd4
    } alusel_e;

    function automatic alusel_e alu_class(aluop_e op);
        case (op)
            ALU_ADD, ALU_SUB:           return SEL_ARITH;
            ALU_SLT, ALU_SLTU:          return SEL_CMP;
            ALU_XOR, ALU_OR, ALU_AND:   return SEL_LOGIC;
            ALU_SLL, ALU_SRL, ALU_SRA:  return SEL_SHIFT;
            default:                    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stage_id_pipe_fwd_mux.sv
// Single-operand resolver: immediate, x0, lowest-index bypass port, else
// register file. Flags a hazard when the chosen bypass is not ready yet.
module id_fwd_mux #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  logic                      re,
    input  logic [REG_AW-1:0]         addr,
    input  logic [XLEN-1:0]           rf_data,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    input  logic [XLEN-1:0]           imm,
    output logic [XLEN-1:0]           opv,
    output logic                      hazard
);

    logic hit;

    always_comb begin
        opv    = rf_data;
        hazard = 1'b0;
        hit    = 1'b0;
        if (!re) begin
            opv = imm;
        end else if (addr == '0) begin
            opv = '0;
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!hit && fwd_we[i] && (fwd_addr[i*REG_AW +: REG_AW] == addr)) begin
                    hit    = 1'b1;
                    opv    = fwd_data[i*XLEN +: XLEN];
                    hazard = !fwd_rdy[i];
                end
            end
        end
    end

endmodule

// File: rtl/stage_id_pipe.sv
// RV32I decode stage owning the ID/EX register (OP, OP-IMM, LUI, LOAD).
// Define STAGE_ID_PIPE_PERF_EN to add saturating stall/illegal counters.
module stage_id_pipe
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [31:0]               in_inst,
    output logic [REG_AW-1:0]         rf_addr1,
    output logic [REG_AW-1:0]         rf_addr2,
    output logic                      rf_re1,
    output logic                      rf_re2,
    input  logic [XLEN-1:0]           rf_data1,
    input  logic [XLEN-1:0]           rf_data2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALUOP_W-1:0]        out_aluop,
    output logic [ALUSEL_W-1:0]       out_alusel,
    output logic [XLEN-1:0]           out_opv1,
    output logic [XLEN-1:0]           out_opv2,
    output logic [REG_AW-1:0]         out_waddr,
    output logic                      out_we,
    output logic                      out_is_load,
    output logic [2:0]                out_mem_f3,
    output logic                      out_illegal
`ifdef STAGE_ID_PIPE_PERF_EN
   ,output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_illegal_cnt
`endif
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    aluop_e          aluop;
    logic            illegal, re1, re2, we, is_load;
    logic [XLEN-1:0] imm2, opv1, opv2;
    logic            haz1, haz2, hazard, accept;
    logic            unused_pc;

    assign opcode    = in_inst[6:0];
    assign f3        = in_inst[14:12];
    assign f7        = in_inst[31:25];
    assign unused_pc = ^in_pc;

    always_comb begin
        aluop   = ALU_NOP;
        illegal = 1'b0;
        re1     = 1'b0;
        re2     = 1'b0;
        we      = 1'b0;
        is_load = 1'b0;
        imm2    = '0;
        case (opcode)
            OPC_OP: begin
                re1 = 1'b1;
                re2 = 1'b1;
                we  = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  aluop = ALU_ADD;
                        F3_SLL:  aluop = ALU_SLL;
                        F3_SLT:  aluop = ALU_SLT;
                        F3_SLTU: aluop = ALU_SLTU;
                        F3_XOR:  aluop = ALU_XOR;
                        F3_SR:   aluop = ALU_SRL;
                        F3_OR:   aluop = ALU_OR;
                        default: aluop = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    aluop = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    aluop = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                re1  = 1'b1;
                we   = 1'b1;
                imm2 = XLEN'($signed(in_inst[31:20]));
                case (f3)
                    F3_ADD:  aluop = ALU_ADD;
                    F3_SLT:  aluop = ALU_SLT;
                    F3_SLTU: aluop = ALU_SLTU;
                    F3_XOR:  aluop = ALU_XOR;
                    F3_OR:   aluop = ALU_OR;
                    F3_AND:  aluop = ALU_AND;
                    F3_SLL: begin
                        imm2 = XLEN'(in_inst[24:20]);
                        if (f7 == F7_BASE) aluop = ALU_SLL;
                        else               illegal = 1'b1;
                    end
                    default: begin
                        imm2 = XLEN'(in_inst[24:20]);
                        if (f7 == F7_BASE)     aluop = ALU_SRL;
                        else if (f7 == F7_ALT) aluop = ALU_SRA;
                        else                   illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                we    = 1'b1;
                aluop = ALU_ADD;
                imm2  = XLEN'({in_inst[31:12], 12'b0});
            end
            OPC_LOAD: begin
                re1     = 1'b1;
                we      = 1'b1;
                is_load = 1'b1;
                aluop   = ALU_ADD;
                imm2    = XLEN'($signed(in_inst[31:20]));
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // An undecodable word must not read, write or stall on anything.
        if (illegal) begin
            aluop   = ALU_NOP;
            re1     = 1'b0;
            re2     = 1'b0;
            we      = 1'b0;
            is_load = 1'b0;
            imm2    = '0;
        end
    end

    assign rf_addr1 = REG_AW'(in_inst[19:15]);
    assign rf_addr2 = REG_AW'(in_inst[24:20]);
    assign rf_re1   = re1;
    assign rf_re2   = re2;

    id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_op1 (
        .re(re1), .addr(rf_addr1), .rf_data(rf_data1),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
        .imm('0), .opv(opv1), .hazard(haz1)
    );

    id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_op2 (
        .re(re2), .addr(rf_addr2), .rf_data(rf_data2),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
        .imm(imm2), .opv(opv2), .hazard(haz2)
    );

    assign hazard   = haz1 | haz2;
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_aluop   <= '0;
            out_alusel  <= '0;
            out_opv1    <= '0;
            out_opv2    <= '0;
            out_waddr   <= '0;
            out_we      <= 1'b0;
            out_is_load <= 1'b0;
            out_mem_f3  <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_aluop   <= aluop;
            out_alusel  <= alu_class(aluop);
            out_opv1    <= opv1;
            out_opv2    <= opv2;
            out_waddr   <= REG_AW'(in_inst[11:7]);
            out_we      <= we;
            out_is_load <= is_load;
            out_mem_f3  <= is_load ? f3 : 3'd0;
            out_illegal <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STAGE_ID_PIPE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt   <= '0;
            perf_illegal_cnt <= '0;
        end else begin
            if (in_valid && hazard && !flush && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (accept && illegal && !(&perf_illegal_cnt))
                perf_illegal_cnt <= perf_illegal_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised successor to the combinational decode stage: a RISC-V RV32I integer decode stage that owns the ID/EX pipeline register.
- Decodes OP, OP-IMM, LUI and LOAD, and resolves operands from the register file or from NUM_FWD bypass ports.
- Detects load-use hazards and stalls for them.
- Exchanges instructions with IF and EX through valid/ready handshakes; supports flush.

Parameters:
- XLEN, 32, datapath/register width.
- NUM_FWD, 2, number of bypass ports; port 0 has the highest priority (youngest producer).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  this stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction address.
- in_inst  in  32  instruction word.
- rf_addr1, rf_addr2  out  REG_AW each  register-file read addresses (combinational from in_inst).
- rf_re1, rf_re2  out  1 each  register-file read enables.
- rf_data1, rf_data2  in  XLEN each  register-file read data, same cycle.
- fwd_we  in  NUM_FWD  per-port write enable.
- fwd_addr  in  NUM_FWD*REG_AW  packed destination addresses.
- fwd_data  in  NUM_FWD*XLEN  packed result data.
- fwd_rdy  in  NUM_FWD  data is valid now; 0 = load still in flight.
- flush  in  1  kill the in-flight instruction and the ID/EX register.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts the instruction.
- out_aluop  out  ALUOP_W  ALU operation.
- out_alusel  out  ALUSEL_W  result-select class.
- out_opv1, out_opv2  out  XLEN each  resolved operands.
- out_waddr  out  REG_AW  destination register.
- out_we  out  1  destination write enable.
- out_is_load  out  1  instruction is a LOAD.
- out_mem_f3  out  3  LOAD funct3 (width/sign).
- out_illegal  out  1  undecodable instruction.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including out_valid.
- Decode:
  - OP/OP-IMM as standard RV32I.
  - All I-type immediates are sign-extended, including XORI/ORI/ANDI.
  - Shift-immediate operand = zero-extended inst[24:20]; inst[25]=1 on a shift is illegal.
  - LUI: opv1=0, opv2={inst[31:12],12'b0}, aluop ADD.
  - LOAD: opv1=rs1, opv2=sext(imm), aluop ADD, is_load=1, we=1.
  - Any other opcode or funct: out_illegal=1, we=0, re1=re2=0.
- Operand resolution per operand, in priority order:
  - re=0 → immediate/zero.
  - addr==0 → 0; x0 is never forwarded.
  - Lowest-index port with fwd_we & addr match → that port's fwd_data.
  - Otherwise → rf_data.
- hazard = the selected matching port has fwd_rdy=0 on an enabled operand.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- accept = in_valid & in_ready: load the ID/EX register with decoded fields, set out_valid=1.
- If out_valid & out_ready & !accept: out_valid←0 (bubble). Other fields hold their value; their content is don't-care when out_valid=0.
- If out_valid & !out_ready: all outputs hold stable (no accept is possible).
- flush=1: out_valid←0 at the next edge; in_ready=0 that cycle. flush has priority over accept.
- Latency: exactly 1 cycle from accept to out_valid.
- Back-to-back: full throughput when out_ready=1 and there is no hazard.
- Simultaneous hazard and out_ready: a bubble is inserted; the stalled instruction is re-evaluated each cycle.

Optional Feature:
- Macro: STAGE_ID_PIPE_PERF_EN.
- When defined, two ports are added:
  - perf_stall_cnt  out  32  counts cycles with in_valid & hazard & !flush.
  - perf_illegal_cnt  out  32  counts accepted illegal instructions.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package rv_pkg:
  - opcode/funct3/funct7 constants;
  - ALUOP_W=8 and ALUSEL_W=3;
  - the ALU op and result-select enumerations.
- One sub-module, id_fwd_mux: resolves a single operand. Inputs: re, addr, rf_data, fwd buses, imm. Outputs: opv, hazard. Instantiated twice.

Test Plan:
- Reset: rst_n=0 with in_valid=1 → all outputs 0. Release rst_n, then send ADDI x1,x0,-5 → out_opv2=32'hFFFF_FFFB, out_waddr=1, out_we=1, out_valid exactly 1 cycle later.
- Forwarding priority: ADD x3,x1,x2 with port0 (x1=32'h11, rdy=1) and port1 (x1=32'h22) → opv1=32'h11. Same stimulus with x0 as the source and the ports matching x0 → opv1=0.
- Load-use: port0 we=1, addr=5, rdy=0; send SUB x6,x5,x7 → in_ready=0 and out_valid drops after out_ready. Set rdy=1 with data 32'h80 → accepted, opv1=32'h80.
- Backpressure: out_ready=0 for 3 cycles → outputs stable and in_ready=0. Raise out_ready → next instruction issues the following cycle.
- Flush: assert flush while out_valid=1 and in_valid=1 → out_valid=0 next cycle; the instruction is not accepted.
- Illegal: opcode 7'b1111111 → out_illegal=1, out_we=0. With STAGE_ID_PIPE_PERF_EN defined, perf_illegal_cnt increments by 1.
